// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo
//   Captures the core's per-instruction retire record on every update_i and
//   buffers it in a DEPTH-entry first-word-fall-through FIFO. The head record
//   is presented on a valid/ready stream to a trace sink. The core is never
//   back-pressured: a record that arrives while the FIFO is full and the head
//   is not leaving is dropped, counted in a saturating counter, and latched
//   in a sticky overflow flag.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   update_i               retire strobe
//   pc_i .. mem_data_i     retire record fields
//   clear_i                synchronous flush of FIFO, drop counter and flag
//   trace_valid_o/ready_i  head handshake
//   trace_*_o              head record fields, zero while not valid
//   count_o                occupancy (0..DEPTH)
//   drop_cnt_o             saturating drop count
//   overflow_o             sticky drop flag
module retire_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     clear_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [XLEN-1:0]          trace_instr_o,
  output logic [4:0]               trace_reg_addr_o,
  output logic [XLEN-1:0]          trace_reg_data_o,
  output logic [XLEN-1:0]          trace_mem_addr_o,
  output logic [XLEN-1:0]          trace_mem_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          wr_rec;
  rec_t          head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          valid, full, pop, push, drop;

  assign wr_rec = '{pc: pc_i, instr: instr_i, reg_addr: reg_addr_i,
                    reg_data: reg_data_i, mem_addr: mem_addr_i,
                    mem_data: mem_data_i};

  // valid comes only from registered occupancy, so update_i never reaches
  // the sink combinationally; a push becomes visible one edge later.
  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
  assign pop   = valid & trace_ready_i;
  // A full FIFO still accepts a record when the head leaves the same cycle.
  assign push  = update_i & (~full | pop);
  assign drop  = update_i & full & ~pop;

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem[wptr] <= wr_rec;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      // Flush wins over everything else this cycle, including a retiring
      // record: it is neither stored nor counted as a drop.
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != CNT_MAX) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  // Head is gated by valid so that stale storage never leaks out, and so the
  // outputs fall to zero the instant reset clears the occupancy.
  assign head = valid ? mem[rptr] : '0;

  assign trace_valid_o    = valid;
  assign trace_pc_o       = head.pc;
  assign trace_instr_o    = head.instr;
  assign trace_reg_addr_o = head.reg_addr;
  assign trace_reg_data_o = head.reg_data;
  assign trace_mem_addr_o = head.mem_addr;
  assign trace_mem_data_o = head.mem_data;
  assign count_o          = count;

endmodule

// File: tb/tb_retire_trace_fifo.sv
module tb_retire_trace_fifo;

  localparam int RW = 5*32 + 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        update, clear, ready;
  logic [31:0] pc, instr, reg_data, mem_addr, mem_data;
  logic [4:0]  reg_addr;

  logic        t_valid;
  logic [31:0] t_pc, t_instr, t_reg_data, t_mem_addr, t_mem_data;
  logic [4:0]  t_reg_addr;
  logic [3:0]  t_count;
  logic [15:0] t_drop;
  logic        t_ovf;

  // Small instance sharing the same stimulus, used to reach drop-counter
  // saturation in a few cycles.
  logic        s_valid;
  logic [31:0] s_pc, s_instr, s_reg_data, s_mem_addr, s_mem_data;
  logic [4:0]  s_reg_addr;
  logic [1:0]  s_count;
  logic [2:0]  s_drop;
  logic        s_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  retire_trace_fifo #(.XLEN(32), .DEPTH(8), .CNT_W(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .update_i(update), .pc_i(pc), .instr_i(instr),
    .reg_addr_i(reg_addr), .reg_data_i(reg_data), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data), .clear_i(clear), .trace_valid_o(t_valid),
    .trace_ready_i(ready), .trace_pc_o(t_pc), .trace_instr_o(t_instr),
    .trace_reg_addr_o(t_reg_addr), .trace_reg_data_o(t_reg_data),
    .trace_mem_addr_o(t_mem_addr), .trace_mem_data_o(t_mem_data),
    .count_o(t_count), .drop_cnt_o(t_drop), .overflow_o(t_ovf));

  retire_trace_fifo #(.XLEN(32), .DEPTH(2), .CNT_W(3)) dut_s (
    .clk_i(clk), .rstn_i(rstn), .update_i(update), .pc_i(pc), .instr_i(instr),
    .reg_addr_i(reg_addr), .reg_data_i(reg_data), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data), .clear_i(clear), .trace_valid_o(s_valid),
    .trace_ready_i(ready), .trace_pc_o(s_pc), .trace_instr_o(s_instr),
    .trace_reg_addr_o(s_reg_addr), .trace_reg_data_o(s_reg_data),
    .trace_mem_addr_o(s_mem_addr), .trace_mem_data_o(s_mem_data),
    .count_o(s_count), .drop_cnt_o(s_drop), .overflow_o(s_ovf));

  typedef struct {
    logic        upd;
    logic        rdy;
    logic [31:0] pc;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [3:0]  exp_cnt;
    logic [15:0] exp_drop;
    logic        exp_ovf;
  } vec_t;

  vec_t vt[$];

  // Record fields other than pc are derived from pc so a single number
  // identifies a whole record.
  function automatic logic [RW-1:0] rec(input logic [31:0] p);
    return {p, p ^ 32'hA5A5_0000, p[6:2], p + 32'd1, p << 1, ~p};
  endfunction

  function automatic logic [RW-1:0] outs();
    return {t_pc, t_instr, t_reg_addr, t_reg_data, t_mem_addr, t_mem_data};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic v, input logic [31:0] p,
                           input logic [3:0] c, input logic [15:0] d, input logic o);
    check({name, ".valid"}, RW'(t_valid), RW'(v));
    check({name, ".rec"},   outs(), v ? rec(p) : '0);
    check({name, ".count"}, RW'(t_count), RW'(c));
    check({name, ".drop"},  RW'(t_drop), RW'(d));
    check({name, ".ovf"},   RW'(t_ovf), RW'(o));
  endtask

  task automatic drive(input logic u, input logic r, input logic c,
                       input logic [31:0] p);
    logic [RW-1:0] r_;
    r_ = rec(p);
    update = u; ready = r; clear = c;
    {pc, instr, reg_addr, reg_data, mem_addr, mem_data} = r_;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic u, input logic r, input logic [31:0] p,
                     input logic v, input logic [31:0] ep, input logic [3:0] c,
                     input logic [15:0] d, input logic o);
    vec_t e;
    e.upd = u; e.rdy = r; e.pc = p; e.exp_v = v; e.exp_pc = ep;
    e.exp_cnt = c; e.exp_drop = d; e.exp_ovf = o;
    vt.push_back(e);
  endtask

  initial begin
    // Fill from an empty FIFO with drop count 0: 10 pushes, 2 dropped.
    for (int k = 1; k <= 10; k++)
      add(1, 0, 32'(4*(k-1)), 1, 32'h0, (k > 8) ? 4'd8 : 4'(k),
          (k > 8) ? 16'(k-8) : 16'd0, k > 8);
    // Drain in order.
    for (int j = 1; j <= 8; j++)
      add(0, 1, 32'h0, j < 8, (j < 8) ? 32'(4*j) : 32'h0, 4'(8-j), 16'd2, 1);
    // Refill, then push and pop together while full.
    for (int k = 1; k <= 8; k++)
      add(1, 0, 32'h100 + 32'(4*(k-1)), 1, 32'h100, 4'(k), 16'd2, 1);
    add(1, 1, 32'h120, 1, 32'h104, 4'd8, 16'd2, 1);
    for (int j = 1; j <= 8; j++)
      add(0, 1, 32'h0, j < 8, (j < 8) ? 32'h104 + 32'(4*j) : 32'h0,
          4'(8-j), 16'd2, 1);

    // Reset
    rstn = 1'b0;
    drive(0, 0, 0, 32'h0);
    step(); step();
    chk_state("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk_state("idle", 0, 0, 0, 0, 0);

    // Single record with exact field values
    update = 1; ready = 0; clear = 0;
    pc = 32'h10; instr = 32'h0050_0093; reg_addr = 5'd1; reg_data = 32'd5;
    mem_addr = 32'h0; mem_data = 32'h0;
    step();
    drive(0, 0, 0, 32'h0);
    check("single.valid", RW'(t_valid), RW'(1'b1));
    check("single.rec", outs(),
          {32'h10, 32'h0050_0093, 5'd1, 32'd5, 32'h0, 32'h0});
    check("single.count", RW'(t_count), RW'(4'd1));
    step();
    check("single.stable", outs(),
          {32'h10, 32'h0050_0093, 5'd1, 32'd5, 32'h0, 32'h0});
    drive(0, 1, 0, 32'h0);
    step();
    chk_state("single.pop", 0, 0, 0, 0, 0);

    // Table: fill/overflow/drain/full push+pop
    foreach (vt[i]) begin
      drive(vt[i].upd, vt[i].rdy, 0, vt[i].pc);
      step();
      chk_state($sformatf("vec%0d", i), vt[i].exp_v, vt[i].exp_pc,
                vt[i].exp_cnt, vt[i].exp_drop, vt[i].exp_ovf);
    end

    // Continuous stream: one push and one pop each cycle
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, 0, 32'h1000 + 32'(4*i));
      step();
      check($sformatf("stream%0d.pc", i), RW'(t_pc), RW'(32'h1000 + 32'(4*i)));
      check($sformatf("stream%0d.cnt", i), RW'(t_count), RW'(4'd1));
    end
    drive(0, 1, 0, 32'h0);
    step();
    chk_state("stream.end", 0, 0, 0, 2, 1);

    // Clear with a record retiring the same cycle
    drive(0, 0, 1, 32'h0);
    step();
    chk_state("clr1", 0, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      drive(1, 0, 0, 32'h2000 + 32'(4*k));
      step();
    end
    drive(0, 1, 0, 32'h0);
    step(); step(); step();
    chk_state("pre_clr", 1, 32'h200C, 5, 3, 1);
    drive(1, 1, 1, 32'h3000);
    step();
    chk_state("clr2", 0, 0, 0, 0, 0);

    // Drop counter saturation on the narrow-counter instance
    for (int k = 0; k < 12; k++) begin
      drive(1, 0, 0, 32'h4000 + 32'(4*k));
      step();
      if (k == 7) check("sat.mid", RW'(s_drop), RW'(3'd6));
    end
    check("sat.hold", RW'(s_drop), RW'(3'd7));
    check("sat.ovf", RW'(s_ovf), RW'(1'b1));
    chk_state("sat.main", 1, 32'h4000, 8, 4, 1);

    // Asynchronous reset in the middle of a drain
    drive(0, 0, 1, 32'h0);
    step();
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 0, 32'h5000 + 32'(4*k));
      step();
    end
    drive(0, 1, 0, 32'h0);
    step();
    chk_state("pre_rst", 1, 32'h5004, 7, 1, 1);
    #2 rstn = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk_state("post_rst", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Sits directly downstream of the core's retire port and consumes the per-instruction retire record (update/pc/instr/reg/mem fields) every cycle the core asserts update.
- Buffers records in a DEPTH-entry first-word-fall-through FIFO and presents them on a valid/ready stream to a trace sink (bench scoreboard, debug UART bridge).
- Never stalls the core: it drops records when full and counts the drops.

Parameters:
XLEN, 32, data/address width of retire fields
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 16, width of saturating drop counter

Ports:
clk_i  input  1  system clock
rstn_i  input  1  system reset
update_i  input  1  retire strobe from core
pc_i  input  XLEN  retired program counter
instr_i  input  XLEN  retired instruction
reg_addr_i  input  5  retired rd address
reg_data_i  input  XLEN  retired rd data
mem_addr_i  input  XLEN  retired memory address
mem_data_i  input  XLEN  retired memory data
clear_i  input  1  synchronous flush of FIFO, counters, flag
trace_valid_o  output  1  head record available
trace_ready_i  input  1  sink accepts head record
trace_pc_o  output  XLEN  head pc
trace_instr_o  output  XLEN  head instruction
trace_reg_addr_o  output  5  head rd address
trace_reg_data_o  output  XLEN  head rd data
trace_mem_addr_o  output  XLEN  head memory address
trace_mem_data_o  output  XLEN  head memory data
count_o  output  $clog2(DEPTH)+1  current occupancy
drop_cnt_o  output  CNT_W  records dropped since reset/clear
overflow_o  output  1  sticky: at least one drop occurred

Behaviour:
- Interface: one clock (clk_i); reset rstn_i is asynchronous, active-low.
- Reset:
  - Pointers, count_o, drop_cnt_o, overflow_o = 0.
  - trace_valid_o = 0; all trace_*_o = 0.
  - Storage array need not reset.
- Record: 5*XLEN+5 bits = {pc, instr, reg_addr, reg_data, mem_addr, mem_data}, stored verbatim.
- pop = trace_valid_o && trace_ready_i.
- push = update_i && (!full || pop).
  - Full with simultaneous pop: the write is accepted.
- drop = update_i && full && !pop:
  - drop_cnt_o increments, saturating at 2^CNT_W-1.
  - overflow_o is set and stays set.
- Empty: trace_valid_o = (count_o != 0). Full: count_o == DEPTH.
- Head presentation:
  - trace_*_o show the entry at the read pointer.
  - They are forced to 0 when trace_valid_o = 0.
  - They are stable while trace_valid_o && !trace_ready_i.
- Latency:
  - A record pushed at edge N is visible on outputs after edge N if the FIFO was empty, i.e. 1 cycle.
  - There is no combinational bypass from update_i to trace_valid_o.
- Occupancy:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count_o +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
  - Push+pop while empty cannot occur, because pop requires valid.
- Ordering: strict FIFO; records leave in retire order.
- clear_i:
  - At the next edge, empties the FIFO and zeroes count_o, drop_cnt_o, overflow_o.
  - Overrides any push/pop/drop in the same cycle; a record retiring that cycle is discarded and not counted.
- Reset asserted mid-stream: all state returns to reset values asynchronously; the buffered records are lost.
- trace_ready_i with trace_valid_o = 0 has no effect.

Test Plan:
1. Reset, hold trace_ready_i=0, pulse update_i once with pc_i=0x0000_0010, instr_i=0x0050_0093, reg_addr_i=1, reg_data_i=5 -> trace_valid_o=1 next cycle; outputs match exactly; count_o=1.
2. With trace_ready_i=0, push 10 records with pc 0x00,0x04,...,0x24, DEPTH=8 -> count_o=8, drop_cnt_o=2, overflow_o=1. Then raise ready -> 8 records drain in order with pc 0x00..0x1C; valid drops after the eighth.
3. With the FIFO full and trace_ready_i=1, pulse update_i -> push and pop in the same cycle; count_o stays 8; drop_cnt_o unchanged.
4. Keep update_i=1 and trace_ready_i=1 continuously for 100 cycles with incrementing pc -> every pc appears exactly once, in order; count_o oscillates at most 0..1; no drops.
5. With the FIFO at 5 entries and drop_cnt_o=3, assert clear_i together with update_i -> next cycle count_o=0, trace_valid_o=0, drop_cnt_o=0, overflow_o=0.
6. Preload drop_cnt_o to 0xFFFF by forcing drops with CNT_W=16 -> further drops hold 0xFFFF. Separately, assert rstn_i=0 mid-drain -> outputs zero immediately, without waiting for a clock edge.
